// File: rtl/clk_divider_pkg.sv
// Shared definitions for the programmable clock divider.
package clk_divider_pkg;

    localparam int CLK_DIVIDER_WIDTH_DEFAULT = 8;

    typedef logic [CLK_DIVIDER_WIDTH_DEFAULT-1:0] clk_div_cnt_t;

endpackage : clk_divider_pkg

// File: rtl/clk_divider_counter.sv
// Half-period counter: counts up from 0 and flags when it reaches last_i.
module clk_divider_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] last_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // The owner clears on terminal count, so the count never passes last_i.
    always_comb begin
        cnt_d = cnt_q + WIDTH'(1);
        if (clr_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == last_i);

endmodule : clk_divider_counter

// File: rtl/clk_divider.sv
// Programmable 50%-duty clock divider, period 2*scale input cycles.
// Optional registered rise-aligned tick output under CLK_DIVIDER_TICK_EN.
module clk_divider
    import clk_divider_pkg::*;
#(
    parameter int WIDTH = CLK_DIVIDER_WIDTH_DEFAULT
) (
    input  logic             clk_in,
    input  logic             nrst,
    input  logic [WIDTH-1:0] scale,
`ifdef CLK_DIVIDER_TICK_EN
    output logic             tick,
`endif
    output logic             clk_out
);

    logic [WIDTH-1:0] scale_q;
    logic [WIDTH-1:0] scale_d;
    logic             clk_out_q;
    logic             clk_out_d;
    logic [WIDTH-1:0] last;
    logic [WIDTH-1:0] cnt;
    logic             tc;
    logic             disabled;
    logic             toggle;
    logic             cnt_clr;

    assign disabled = (scale_q == '0);
    // With scale_q == 0 this wraps, but the counter is held clear then.
    assign last     = scale_q - WIDTH'(1);
    assign toggle   = !disabled && tc;
    assign cnt_clr  = nrst || disabled || tc;

    clk_divider_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk_i  (clk_in),
        .clr_i  (cnt_clr),
        .last_i (last),
        .cnt_o  (cnt),
        .tc_o   (tc)
    );

    always_comb begin
        scale_d   = scale_q;
        clk_out_d = clk_out_q;
        if (disabled) begin
            scale_d   = scale;
            clk_out_d = 1'b0;
        end else if (toggle) begin
            scale_d   = scale;
            clk_out_d = ~clk_out_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (nrst) begin
            scale_q   <= scale;
            clk_out_q <= 1'b0;
        end else begin
            scale_q   <= scale_d;
            clk_out_q <= clk_out_d;
        end
    end

    assign clk_out = clk_out_q;

`ifdef CLK_DIVIDER_TICK_EN
    logic tick_q;
    logic tick_d;

    // High in the cycle clk_out becomes 1.
    assign tick_d = toggle && !clk_out_q;

    always_ff @(posedge clk_in) begin
        if (nrst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
`endif

    logic unused_cnt;
    assign unused_cnt = ^cnt;

endmodule : clk_divider

// File: tb/tb_clk_divider.sv
// Self-checking bench for clk_divider: directed scenarios plus random scale/reset
// traffic compared against a countdown reference model.
module tb_clk_divider;
    import clk_divider_pkg::*;

    logic         clk_in;
    logic         nrst;
    clk_div_cnt_t scale;
    logic         clk_out;
    logic         tick;

    int n_checks;
    int n_pass;
    int n_fail;

    // Expected {tick, clk_out} after each edge.
    logic [1:0] exp_q[$];

    // Reference model: edges left in the current half-period.
    logic m_out;
    int   m_active;
    int   m_left;

    clk_divider #(
        .WIDTH (CLK_DIVIDER_WIDTH_DEFAULT)
    ) dut (
        .clk_in  (clk_in),
        .nrst    (nrst),
        .scale   (scale),
`ifdef CLK_DIVIDER_TICK_EN
        .tick    (tick),
`endif
        .clk_out (clk_out)
    );

`ifndef CLK_DIVIDER_TICK_EN
    assign tick = 1'b0;
`endif

    // Clock and watchdog
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic model_edge(input logic rst, input int sc);
        logic t;
        t = 1'b0;
        if (rst || m_active == 0) begin
            m_out    = 1'b0;
            m_active = sc;
            m_left   = sc;
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_out    = !m_out;
                t        = m_out;
                m_active = sc;
                m_left   = sc;
            end
        end
        exp_q.push_back({t, m_out});
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        n_checks++;
        assert (got == exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic scoreboard_check();
        logic [1:0] e;
        if (exp_q.size() == 0) begin
            check_int("sb_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            check_bit("sb_clk_out", clk_out, e[0]);
`ifdef CLK_DIVIDER_TICK_EN
            check_bit("sb_tick", tick, e[1]);
`endif
        end
    endtask

    // Driver: apply inputs, take one edge, update model, check away from the edge.
    task automatic step(input logic rst, input int sc);
        nrst  = rst;
        scale = clk_div_cnt_t'(sc);
        @(posedge clk_in);
        model_edge(rst, sc);
        #1;
        scoreboard_check();
    endtask

    task automatic run_until_change(input int sc, output int n);
        logic start;
        start = clk_out;
        n = 0;
        do begin
            step(1'b0, sc);
            n++;
        end while (clk_out === start && n < 2000);
        if (n >= 2000) check_int("change_timeout", n, 0);
    endtask

    initial begin
        int n;
        int hi;
        int lo;
        int ticks;
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        m_out    = 1'b0;
        m_active = 0;
        m_left   = 0;
        nrst     = 1'b1;
        scale    = '0;

        // Reset and default ratio
        step(1'b1, 3);
        check_bit("reset_low_1", clk_out, 1'b0);
        step(1'b1, 3);
        check_bit("reset_low_2", clk_out, 1'b0);
        run_until_change(3, n);
        check_int("first_rise_3", n, 3);
        run_until_change(3, n);
        check_int("high_len_3", n, 3);
        run_until_change(3, n);
        check_int("low_len_3", n, 3);

        // Scale change mid-high-phase: the half-period in progress finishes at 3
        step(1'b0, 6);
        run_until_change(6, n);
        check_int("old_half_rest", n + 1, 3);
        run_until_change(6, n);
        check_int("new_low_len_6", n, 6);
        check_bit("high_before_reset", clk_out, 1'b1);

        // Reset mid-operation
        step(1'b1, 6);
        check_bit("mid_reset_low", clk_out, 1'b0);
        step(1'b1, 6);
        run_until_change(6, n);
        check_int("rise_after_reset_6", n, 6);

        // scale = 1: first half-period still uses 6, then every cycle
        run_until_change(1, n);
        check_int("scale1_latency", n, 6);
        for (int i = 0; i < 4; i++) begin
            run_until_change(1, n);
            check_int("scale1_toggle", n, 1);
        end

        // scale = 0: disabled, output held low
        step(1'b0, 0);
        step(1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 0);
            check_bit("disabled_low", clk_out, 1'b0);
        end
        // One edge loads the new scale, then 2 edges of counting
        run_until_change(2, n);
        check_int("restart_from_0_to_2", n, 3);

        // scale = 255: no wrap, period 510
        run_until_change(255, n);
        run_until_change(255, hi);
        run_until_change(255, lo);
        check_int("half_255_a", hi, 255);
        check_int("half_255_b", lo, 255);
        check_int("period_510", hi + lo, 510);

`ifdef CLK_DIVIDER_TICK_EN
        // Tick: one pulse per rise, none in reset
        step(1'b1, 3);
        check_bit("tick_reset", tick, 1'b0);
        step(1'b1, 3);
        check_bit("tick_reset", tick, 1'b0);
        ticks = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 3);
            if (tick === 1'b1) begin
                ticks++;
                check_bit("tick_with_rise", clk_out, 1'b1);
            end
        end
        check_int("tick_count_60", ticks, 10);
`else
        ticks = 0;
`endif

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                step(1'b1, $urandom_range(0, 9));
            end else if ($urandom_range(0, 7) == 0) begin
                step(1'b0, $urandom_range(0, 9));
            end else begin
                step(1'b0, int'(scale));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_clk_divider
